load_sequencer: RTL and testbench
=================================

LOAD_SEQUENCER -- requirements
Module: load_sequencer

Interface
REQ-001 Parameter N, default 4, SHALL set the width of interval and data buses.
REQ-002 Parameter WD_LIMIT, default 2**N+2, SHALL set the done-wait watchdog limit in clk cycles.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on posedge clk.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  input  1  SHALL request a run; sampled only in IDLE.
REQ-006 interval_a  input  N  SHALL be the phase-A count; sampled when start is accepted.
REQ-007 interval_b  input  N  SHALL be the phase-B count; sampled when start is accepted.
REQ-008 repeat_cnt  input  4  SHALL be the A+B pair count; sampled when start is accepted; 0 means 16.
REQ-009 load  output  1  SHALL be a one-cycle load strobe to the downstream down-counter.
REQ-010 data  output  N  SHALL be the count value presented with load; held stable while load=1.
REQ-011 done  input  1  SHALL be the terminal-count pulse from the down-counter; sampled as a level each cycle.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.
REQ-013 phase  output  1  SHALL be 0 during phase A and 1 during phase B.
REQ-014 pairs_left  output  4  SHALL be the number of A+B pairs not yet completed.
REQ-015 finished  output  1  SHALL be a one-cycle pulse on normal completion.
REQ-016 timeout  output  1  SHALL be a sticky error flag, cleared only by reset or an accepted start.

Function
REQ-017 States SHALL be IDLE, LOAD_A, WAIT_A, LOAD_B, WAIT_B, FINISH and ERROR.
REQ-018 IDLE with start=1 SHALL latch interval_a, interval_b and repeat_cnt, clear timeout, set pairs_left, and go to LOAD_A.
REQ-019 LOAD_A SHALL drive load=1 and data=latched interval_a for exactly one cycle, then go to WAIT_A.
REQ-020 LOAD_B SHALL drive load=1 and data=latched interval_b for exactly one cycle, then go to WAIT_B.
REQ-021 WAIT_A with done=1 SHALL go to LOAD_B.
REQ-022 WAIT_B with done=1 SHALL decrement pairs_left, then go to FINISH if the result is 0, else to LOAD_A.
REQ-023 An interval of 0 SHALL still issue its load, SHALL skip the wait state, and SHALL take the done=1 transition in the cycle after load, since the counter never signals done for 0.
REQ-024 The watchdog SHALL count cycles spent in WAIT_A or WAIT_B and restart at each entry to a wait state.
REQ-025 Reaching WD_LIMIT without done SHALL set timeout=1, go to ERROR and drive load=0.
REQ-026 ERROR SHALL go to IDLE in the next cycle; timeout SHALL stay set.
REQ-027 FINISH SHALL pulse finished=1 for one cycle, then go to IDLE.
REQ-028 done=1 outside WAIT_A and WAIT_B SHALL be ignored.
REQ-029 start=1 while busy SHALL be ignored; no queueing.
REQ-030 done and a watchdog expiry in the same cycle SHALL resolve in favour of done.
REQ-031 Latency from start to first load SHALL be 1 cycle, and from done in WAIT_x to the next load SHALL be 1 cycle.
REQ-032 All arithmetic SHALL be unsigned, and pairs_left SHALL never wrap below 0.

Reset
REQ-033 Asserting rst SHALL force state=IDLE immediately, independent of clk.
REQ-034 During reset, load=0, data=0, busy=0, phase=0, pairs_left=0, finished=0, timeout=0 and watchdog=0.
REQ-035 Reset mid-run SHALL abandon the sequence without a finished pulse; the first start after release SHALL begin a fresh run.

Structure
REQ-036 A shared package load_seq_pkg SHALL hold the state encoding, default N, and the WD_LIMIT formula.
REQ-037 The watchdog SHALL be a sub-module wait_timer with clk, rst, clear, enable, limit inputs and an expired output.
REQ-038 The FSM and output registers SHALL live in load_sequencer, and all outputs SHALL be registered.

Verification
REQ-039 Bench SHALL close the loop with a behavioural 4-bit down-counter model that loads on load and pulses done when its count reaches 1.
REQ-040 Scenario: start with A=3, B=5, repeat=2 -> loads 3,5,3,5 in order; finished pulses once; pairs_left 2->1->0.
REQ-041 Scenario: A=0, B=2, repeat=1 -> load with data 0, WAIT_A skipped, load with data 2, then finished; timeout=0.
REQ-042 Scenario: A=4 with done tied low -> timeout=1 after 18 cycles in WAIT_A; state returns to IDLE; no finished pulse.
REQ-043 Scenario: rst asserted during WAIT_B -> outputs zero asynchronously; a new start with A=1, B=1, repeat=1 completes normally.
REQ-044 Scenario: start pulsed while busy and a spurious done in LOAD_A -> both ignored; load order and count unchanged.
REQ-045 Scenario: repeat=0 with A=1, B=1 -> exactly 16 pairs run before the finished pulse.

Source files
------------

// File: rtl/load_seq_pkg.sv
// Shared definitions for the load sequencer.
// Holds the FSM state encoding, the default bus width, the done-wait
// watchdog limit formula and the pair-counter helpers.
package load_seq_pkg;

  localparam int N_DEFAULT = 4;

  // Pair counter is one bit wider than repeat_cnt so that a repeat of 0
  // can be held internally as the full count of 16.
  localparam int PAIRS_W = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_WAIT_A = 3'd2,
    S_LOAD_B = 3'd3,
    S_WAIT_B = 3'd4,
    S_FINISH = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  // Longest legal wait is 2**n - 1 cycles; the extra margin keeps the
  // watchdog clear of a correctly behaving counter.
  function automatic int wd_limit(input int n);
    return (2 ** n) + 2;
  endfunction

  function automatic logic [PAIRS_W-1:0] pairs_init(input logic [3:0] rep);
    return (rep == 4'd0) ? PAIRS_W'(16) : {1'b0, rep};
  endfunction

  function automatic logic [PAIRS_W-1:0] pairs_dec(input logic [PAIRS_W-1:0] p);
    return (p != '0) ? (p - PAIRS_W'(1)) : '0;
  endfunction

endpackage

// File: rtl/load_sequencer_wait_timer.sv
// Done-wait watchdog for the load sequencer.
// A down-counter reloaded with limit-1 while clear is high and
// decremented while enable is high; expired flags the terminal count
// during an enabled cycle, i.e. the limit-th consecutive enabled cycle.
// Ports:
//   clk, rst  - clock, async active-high reset (count returns to 0)
//   clear     - reload the count (restart the watchdog)
//   enable    - count this cycle
//   limit     - number of enabled cycles until expiry
//   expired   - terminal count reached in an enabled cycle
module wait_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] remaining;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
    end else if (clear) begin
      remaining <= (limit == '0) ? '0 : (limit - W'(1));
    end else if (enable && (remaining != '0)) begin
      remaining <= remaining - W'(1);
    end
  end

  assign expired = enable && (remaining == '0);

endmodule

// File: rtl/load_sequencer.sv
// Load sequencer: drives a downstream down-counter through repeated
// A/B interval pairs, issuing a one-cycle load strobe per interval and
// waiting for the counter's done pulse, guarded by a watchdog.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   IDLE    | waiting for start; inputs latched on acceptance
//   LOAD_A  | load strobe with interval A
//   WAIT_A  | waiting for done on interval A (watchdog running)
//   LOAD_B  | load strobe with interval B
//   WAIT_B  | waiting for done on interval B (watchdog running)
//   FINISH  | one-cycle finished pulse
//   ERROR   | watchdog expired; timeout set, back to IDLE next
//
// Ports:
//   clk, rst           - clock, async active-high reset
//   start              - run request, only looked at in IDLE
//   interval_a/_b      - phase A/B counts, latched on start
//   repeat_cnt         - number of A+B pairs, 0 means 16
//   load, data         - load strobe and count value to the counter
//   done               - terminal-count level from the counter
//   busy               - high in every state except IDLE
//   phase              - 0 in phase A, 1 in phase B
//   pairs_left         - pairs not yet completed (16 reads as 0)
//   finished           - one-cycle pulse on normal completion
//   timeout            - sticky watchdog error flag
// All outputs come straight from registers, computed from the next state.
module load_sequencer
  import load_seq_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int WD_LIMIT = wd_limit(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] interval_a,
  input  logic [N-1:0] interval_b,
  input  logic [3:0]   repeat_cnt,
  output logic         load,
  output logic [N-1:0] data,
  input  logic         done,
  output logic         busy,
  output logic         phase,
  output logic [3:0]   pairs_left,
  output logic         finished,
  output logic         timeout
);

  localparam int WD_W = $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT_V = WD_W'(WD_LIMIT);

  state_t state_q, state_d;

  logic [N-1:0]       a_q, a_d;
  logic [N-1:0]       b_q, b_d;
  logic [PAIRS_W-1:0] pairs_q, pairs_d;
  logic [PAIRS_W-1:0] pairs_next_dec;
  logic               timeout_q, timeout_d;

  logic               load_q, load_d;
  logic [N-1:0]       data_q, data_d;
  logic               busy_q, busy_d;
  logic               phase_q, phase_d;
  logic               finished_q, finished_d;

  logic               in_wait;
  logic               wd_expired;

  assign in_wait = (state_q == S_WAIT_A) || (state_q == S_WAIT_B);

  // Held in reload outside the wait states, so every entry into a wait
  // state starts a fresh count (waits are always entered from a load).
  wait_timer #(
    .W(WD_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_wait),
    .enable (in_wait),
    .limit  (WD_LIMIT_V),
    .expired(wd_expired)
  );

  assign pairs_next_dec = pairs_dec(pairs_q);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    pairs_d   = pairs_q;
    timeout_d = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d       = interval_a;
          b_d       = interval_b;
          pairs_d   = pairs_init(repeat_cnt);
          timeout_d = 1'b0;
          state_d   = S_LOAD_A;
        end
      end

      // A zero interval never produces done, so its wait is skipped and
      // the done transition is taken straight out of the load state.
      S_LOAD_A: begin
        state_d = (a_q == '0) ? S_LOAD_B : S_WAIT_A;
      end

      S_WAIT_A: begin
        if (done) begin
          state_d = S_LOAD_B;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = S_ERROR;
        end
      end

      S_LOAD_B: begin
        if (b_q == '0) begin
          pairs_d = pairs_next_dec;
          state_d = (pairs_next_dec == '0) ? S_FINISH : S_LOAD_A;
        end else begin
          state_d = S_WAIT_B;
        end
      end

      S_WAIT_B: begin
        if (done) begin
          pairs_d = pairs_next_dec;
          state_d = (pairs_next_dec == '0) ? S_FINISH : S_LOAD_A;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = S_ERROR;
        end
      end

      S_FINISH: state_d = S_IDLE;
      S_ERROR:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    load_d     = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
    data_d     = data_q;
    if (state_d == S_LOAD_A) begin
      data_d = a_d;
    end else if (state_d == S_LOAD_B) begin
      data_d = b_d;
    end
    busy_d     = (state_d != S_IDLE);
    phase_d    = (state_d == S_LOAD_B) || (state_d == S_WAIT_B);
    finished_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      pairs_q    <= '0;
      timeout_q  <= 1'b0;
      load_q     <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      phase_q    <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      pairs_q    <= pairs_d;
      timeout_q  <= timeout_d;
      load_q     <= load_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      phase_q    <= phase_d;
      finished_q <= finished_d;
    end
  end

  assign load       = load_q;
  assign data       = data_q;
  assign busy       = busy_q;
  assign phase      = phase_q;
  assign pairs_left = pairs_q[3:0];
  assign finished   = finished_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_load_sequencer.sv
// Directed bench for load_sequencer, closed around a behavioural 4-bit
// down-counter that loads on load and asserts done while its count is 1.
module tb_load_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] interval_a;
  logic [3:0] interval_b;
  logic [3:0] repeat_cnt;
  logic       load;
  logic [3:0] data;
  logic       done;
  logic       busy;
  logic       phase;
  logic [3:0] pairs_left;
  logic       finished;
  logic       timeout;

  logic       kill_done;
  logic       force_done;
  logic [3:0] cnt_m;

  int n_checks;
  int n_errors;

  int load_log[$];
  int pl_log[$];
  int ph_log[$];
  int busy_cyc;
  int fin_cnt;
  int to_first;

  load_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .interval_a(interval_a),
    .interval_b(interval_b),
    .repeat_cnt(repeat_cnt),
    .load      (load),
    .data      (data),
    .done      (done),
    .busy      (busy),
    .phase     (phase),
    .pairs_left(pairs_left),
    .finished  (finished),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cnt_m <= 4'd0;
    else if (load) cnt_m <= data;
    else if (cnt_m != 4'd0) cnt_m <= cnt_m - 4'd1;
  end

  assign done = ((cnt_m == 4'd1) && !kill_done) || force_done;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One run from IDLE. done_at: cycle to force done high (also releases
  // the done mask); start_at: cycle to re-pulse start with other values.
  // Cycle 1 is the first cycle after start is accepted.
  task automatic run_seq(input int a, input int b, input int rep,
                         input logic kill, input int done_at, input int start_at);
    logic reached_idle;
    load_log.delete();
    pl_log.delete();
    ph_log.delete();
    busy_cyc     = 0;
    fin_cnt      = 0;
    to_first     = 0;
    reached_idle = 1'b0;
    kill_done    = kill;
    @(negedge clk);
    interval_a = 4'(a);
    interval_b = 4'(b);
    repeat_cnt = 4'(rep);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("start_load", int'(load), 1);
    check_val("start_data", int'(data), a);
    check_val("start_busy", int'(busy), 1);
    check_val("start_timeout_clr", int'(timeout), 0);
    for (int i = 1; i <= 200; i++) begin
      if (i > 1) @(negedge clk);
      force_done = (i == done_at);
      if (i == done_at) kill_done = 1'b0;
      if (i == start_at) begin
        start      = 1'b1;
        interval_a = 4'd7;
        interval_b = 4'd9;
        repeat_cnt = 4'd3;
      end else begin
        start = 1'b0;
      end
      if (!busy) begin
        reached_idle = 1'b1;
        break;
      end
      busy_cyc++;
      if (load) begin
        load_log.push_back(int'(data));
        pl_log.push_back(int'(pairs_left));
        ph_log.push_back(int'(phase));
      end
      if (finished) fin_cnt++;
      if (timeout && (to_first == 0)) to_first = i;
    end
    start      = 1'b0;
    force_done = 1'b0;
    check_val("idle_reached", int'(reached_idle), 1);
  endtask

  task automatic cmp_loads(input string tag, input int exp_d[$], input int exp_p[$],
                           input int exp_ph[$]);
    check_val({tag, "_nloads"}, load_log.size(), exp_d.size());
    for (int k = 0; (k < exp_d.size()) && (k < load_log.size()); k++) begin
      check_val($sformatf("%s_data%0d", tag, k), load_log[k], exp_d[k]);
      check_val($sformatf("%s_pairs%0d", tag, k), pl_log[k], exp_p[k]);
      check_val($sformatf("%s_phase%0d", tag, k), ph_log[k], exp_ph[k]);
    end
  endtask

  initial begin
    int ed[$];
    int ep[$];
    int eh[$];
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    start      = 1'b0;
    interval_a = 4'd0;
    interval_b = 4'd0;
    repeat_cnt = 4'd0;
    kill_done  = 1'b0;
    force_done = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_load", int'(load), 0);
    check_val("rst_data", int'(data), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_phase", int'(phase), 0);
    check_val("rst_pairs", int'(pairs_left), 0);
    check_val("rst_finished", int'(finished), 0);
    check_val("rst_timeout", int'(timeout), 0);
    rst = 1'b0;

    // done while idle must not start anything
    @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    check_val("idle_done_busy", int'(busy), 0);
    check_val("idle_done_load", int'(load), 0);

    // A=3 B=5 x2: 2*(1+3+1+5)+1 busy cycles
    run_seq(3, 5, 2, 1'b0, 0, 0);
    check_val("s1_busy_cycles", busy_cyc, 21);
    check_val("s1_finished", fin_cnt, 1);
    check_val("s1_timeout", int'(timeout), 0);
    check_val("s1_pairs_end", int'(pairs_left), 0);
    ed = '{3, 5, 3, 5}; ep = '{2, 2, 1, 1}; eh = '{0, 1, 0, 1};
    cmp_loads("s1", ed, ep, eh);

    // A=0 skips WAIT_A: LOAD_A, LOAD_B, 2 x WAIT_B, FINISH
    run_seq(0, 2, 1, 1'b0, 0, 0);
    check_val("s2_busy_cycles", busy_cyc, 5);
    check_val("s2_finished", fin_cnt, 1);
    check_val("s2_timeout", int'(timeout), 0);
    ed = '{0, 2}; ep = '{1, 1}; eh = '{0, 1};
    cmp_loads("s2", ed, ep, eh);

    // done tied low: LOAD_A, 18 x WAIT_A, ERROR
    run_seq(4, 1, 1, 1'b1, 0, 0);
    check_val("s3_busy_cycles", busy_cyc, 20);
    check_val("s3_finished", fin_cnt, 0);
    check_val("s3_timeout_cycle", to_first, 20);
    check_val("s3_timeout_idle", int'(timeout), 1);
    ed = '{4}; ep = '{1}; eh = '{0};
    cmp_loads("s3", ed, ep, eh);
    repeat (3) @(negedge clk);
    check_val("s3_timeout_sticky", int'(timeout), 1);
    check_val("s3_idle", int'(busy), 0);

    // done arrives in the 18th WAIT_A cycle together with expiry: done wins
    run_seq(4, 1, 1, 1'b1, 19, 0);
    check_val("s3b_busy_cycles", busy_cyc, 22);
    check_val("s3b_finished", fin_cnt, 1);
    check_val("s3b_timeout", int'(timeout), 0);
    ed = '{4, 1}; ep = '{1, 1}; eh = '{0, 1};
    cmp_loads("s3b", ed, ep, eh);

    // spurious done in LOAD_A and start while busy are ignored
    run_seq(2, 3, 2, 1'b0, 1, 3);
    check_val("s5_busy_cycles", busy_cyc, 15);
    check_val("s5_finished", fin_cnt, 1);
    ed = '{2, 3, 2, 3}; ep = '{2, 2, 1, 1}; eh = '{0, 1, 0, 1};
    cmp_loads("s5", ed, ep, eh);

    // reset during WAIT_B
    kill_done = 1'b0;
    @(negedge clk);
    interval_a = 4'd2;
    interval_b = 4'd6;
    repeat_cnt = 4'd1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_val("s4_pre_busy", int'(busy), 1);
    check_val("s4_pre_phase", int'(phase), 1);
    check_val("s4_pre_data", int'(data), 6);
    #2 rst = 1'b1;
    #1;
    check_val("s4_rst_load", int'(load), 0);
    check_val("s4_rst_data", int'(data), 0);
    check_val("s4_rst_busy", int'(busy), 0);
    check_val("s4_rst_phase", int'(phase), 0);
    check_val("s4_rst_pairs", int'(pairs_left), 0);
    check_val("s4_rst_finished", int'(finished), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("s4_post_busy", int'(busy), 0);
    check_val("s4_post_finished", int'(finished), 0);
    run_seq(1, 1, 1, 1'b0, 0, 0);
    check_val("s4b_busy_cycles", busy_cyc, 5);
    check_val("s4b_finished", fin_cnt, 1);
    ed = '{1, 1}; ep = '{1, 1}; eh = '{0, 1};
    cmp_loads("s4b", ed, ep, eh);

    // repeat=0 runs 16 pairs; pairs_left reads 0 (16), 15, ..., 1
    run_seq(1, 1, 0, 1'b0, 0, 0);
    check_val("s6_busy_cycles", busy_cyc, 65);
    check_val("s6_finished", fin_cnt, 1);
    check_val("s6_pairs_end", int'(pairs_left), 0);
    ed.delete(); ep.delete(); eh.delete();
    for (int k = 0; k < 16; k++) begin
      ed.push_back(1); ep.push_back((16 - k) % 16); eh.push_back(0);
      ed.push_back(1); ep.push_back((16 - k) % 16); eh.push_back(1);
    end
    cmp_loads("s6", ed, ep, eh);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
